// File: rtl/multdiv_pkg.sv
// Shared constants and state encoding for the multiply/divide sequencing controller.
package multdiv_pkg;

    localparam int unsigned DFLT_MULT_ITERS = 16;
    localparam int unsigned DFLT_DIV_ITERS  = 32;
    localparam int unsigned DFLT_CNT_W      = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/multdiv_iter_counter.sv
// Iteration counter: synchronous clear, enable, and saturation at the terminal count.
module multdiv_iter_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tc    = (count_q == limit);
    assign count = count_q;

    // Holds at the terminal value instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !tc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// Sequencer for the iterative multiply/divide datapaths (IDLE/LOAD/RUN/DONE).
// Optional multiply-overflow exception enabled by defining MULTDIV_MULT_OVF_EN.
module multdiv_seq_ctrl
    import multdiv_pkg::*;
#(
    parameter int unsigned MULT_ITERS = DFLT_MULT_ITERS,
    parameter int unsigned DIV_ITERS  = DFLT_DIV_ITERS,
    parameter int unsigned CNT_W      = DFLT_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             divisor_zero,
`ifdef MULTDIV_MULT_OVF_EN
    input  logic             mult_ovf,
`endif
    output logic             mult_reg_ena,
    output logic             mult_shift_ena,
    output logic             div_reg_ena,
    output logic             div_shift_ena,
    output logic [CNT_W-1:0] count,
    output logic             op_is_div,
    output logic             busy,
    output logic             stall,
    output logic             data_resultRDY,
    output logic             data_exception
);

    md_state_e state_q, state_d;
    logic      op_is_div_q, op_is_div_d;
    logic      exc_q, exc_d;
    logic      mult_reg_ena_q, mult_reg_ena_d;
    logic      mult_shift_ena_q, mult_shift_ena_d;
    logic      div_reg_ena_q, div_reg_ena_d;
    logic      div_shift_ena_q, div_shift_ena_d;
    logic      busy_q, busy_d;
    logic      rdy_q, rdy_d;
    logic      exc_out_q, exc_out_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_limit;

    assign cnt_clr   = (state_q == LOAD);
    assign cnt_en    = (state_q == RUN);
    assign cnt_limit = op_is_div_q ? CNT_W'(DIV_ITERS - 1) : CNT_W'(MULT_ITERS - 1);

    multdiv_iter_counter #(
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (cnt_limit),
        .count (count),
        .tc    (cnt_tc)
    );

    // Next state; a start in any state restarts through LOAD and drops the current op.
    always_comb begin
        state_d     = state_q;
        op_is_div_d = op_is_div_q;
        exc_d       = exc_q;

        if (ctrl_MULT) begin
            state_d     = LOAD;
            op_is_div_d = 1'b0;
            exc_d       = 1'b0;
        end else if (ctrl_DIV) begin
            state_d     = LOAD;
            op_is_div_d = 1'b1;
            exc_d       = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                LOAD: begin
                    if (op_is_div_q && divisor_zero) begin
                        state_d = DONE;
                        exc_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (cnt_tc) begin
                        state_d = DONE;
`ifdef MULTDIV_MULT_OVF_EN
                        exc_d   = !op_is_div_q && mult_ovf;
`endif
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the next state so they are valid in that state's cycle.
    always_comb begin
        mult_reg_ena_d   = 1'b0;
        mult_shift_ena_d = 1'b0;
        div_reg_ena_d    = 1'b0;
        div_shift_ena_d  = 1'b0;
        busy_d           = 1'b0;
        rdy_d            = 1'b0;
        exc_out_d        = 1'b0;

        if (state_d == LOAD || state_d == RUN) begin
            busy_d         = 1'b1;
            mult_reg_ena_d = !op_is_div_d;
            div_reg_ena_d  = op_is_div_d;
        end
        if (state_d == RUN) begin
            mult_shift_ena_d = !op_is_div_d;
            div_shift_ena_d  = op_is_div_d;
        end
        if (state_d == DONE) begin
            rdy_d     = 1'b1;
            exc_out_d = exc_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            op_is_div_q      <= 1'b0;
            exc_q            <= 1'b0;
            mult_reg_ena_q   <= 1'b0;
            mult_shift_ena_q <= 1'b0;
            div_reg_ena_q    <= 1'b0;
            div_shift_ena_q  <= 1'b0;
            busy_q           <= 1'b0;
            rdy_q            <= 1'b0;
            exc_out_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            op_is_div_q      <= op_is_div_d;
            exc_q            <= exc_d;
            mult_reg_ena_q   <= mult_reg_ena_d;
            mult_shift_ena_q <= mult_shift_ena_d;
            div_reg_ena_q    <= div_reg_ena_d;
            div_shift_ena_q  <= div_shift_ena_d;
            busy_q           <= busy_d;
            rdy_q            <= rdy_d;
            exc_out_q        <= exc_out_d;
        end
    end

    assign mult_reg_ena   = mult_reg_ena_q;
    assign mult_shift_ena = mult_shift_ena_q;
    assign div_reg_ena    = div_reg_ena_q;
    assign div_shift_ena  = div_shift_ena_q;
    assign op_is_div      = op_is_div_q;
    assign busy           = busy_q;
    assign data_resultRDY = rdy_q;
    assign data_exception = exc_out_q;

    // Stall is the one combinational output: it covers the start cycle itself.
    assign stall = busy_q || ((state_q == IDLE) && (ctrl_MULT || ctrl_DIV));

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// Scoreboard bench for multdiv_seq_ctrl: stimulus queues expected samples and result pulses,
// a negedge monitor pops and compares them.
module tb_multdiv_seq_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       ctrl_MULT;
    logic       ctrl_DIV;
    logic       divisor_zero;
`ifdef MULTDIV_MULT_OVF_EN
    logic       mult_ovf;
`endif
    logic       mult_reg_ena;
    logic       mult_shift_ena;
    logic       div_reg_ena;
    logic       div_shift_ena;
    logic [5:0] count;
    logic       op_is_div;
    logic       busy;
    logic       stall;
    logic       data_resultRDY;
    logic       data_exception;

    multdiv_seq_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .divisor_zero   (divisor_zero),
`ifdef MULTDIV_MULT_OVF_EN
        .mult_ovf       (mult_ovf),
`endif
        .mult_reg_ena   (mult_reg_ena),
        .mult_shift_ena (mult_shift_ena),
        .div_reg_ena    (div_reg_ena),
        .div_shift_ena  (div_shift_ena),
        .count          (count),
        .op_is_div      (op_is_div),
        .busy           (busy),
        .stall          (stall),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        logic [14:0] v;
        string       name;
    } samp_t;

    typedef struct {
        int   cyc;
        logic exc;
        logic op;
        string name;
    } rdy_t;

    samp_t samp_q[$];
    rdy_t  rdy_q[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    logic  end_req = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Packing: mr ms dr ds busy stall op rdy exc count[5:0]
    function automatic logic [14:0] vec(input logic mr, input logic ms, input logic dr,
                                        input logic ds, input logic bz, input logic st,
                                        input logic op, input logic rd, input logic ex,
                                        input int cnt);
        return {mr, ms, dr, ds, bz, st, op, rd, ex, 6'(cnt)};
    endfunction

    task automatic push_s(input int at, input logic [14:0] v, input string name);
        samp_t s;
        s.cyc = at; s.v = v; s.name = name;
        samp_q.push_back(s);
    endtask

    task automatic push_r(input int at, input logic exc, input logic op, input string name);
        rdy_t r;
        r.cyc = at; r.exc = exc; r.op = op; r.name = name;
        rdy_q.push_back(r);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: the only process that touches checks/errors.
    always @(negedge clock) begin
        logic [14:0] got;
        samp_t s;
        rdy_t  r;
        got = {mult_reg_ena, mult_shift_ena, div_reg_ena, div_shift_ena, busy, stall,
               op_is_div, data_resultRDY, data_exception, count};
        while (samp_q.size() != 0 && samp_q[0].cyc <= cyc) begin
            s = samp_q.pop_front();
            checks++;
            if (s.cyc != cyc || got !== s.v) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", s.name, cyc, got, s.v);
            end
        end
        while (rdy_q.size() != 0 && rdy_q[0].cyc < cyc) begin
            r = rdy_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s missing resultRDY exp_cyc=%0d now=%0d", r.name, r.cyc, cyc);
        end
        if (data_resultRDY === 1'b1) begin
            checks++;
            if (rdy_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rdy cyc=%0d got=1 exp=0", cyc);
            end else begin
                r = rdy_q.pop_front();
                if (r.cyc != cyc || data_exception !== r.exc || op_is_div !== r.op) begin
                    errors++;
                    $display("FAIL %s cyc=%0d exc=%b op=%b exp_cyc=%0d exc=%b op=%b",
                             r.name, cyc, data_exception, op_is_div, r.cyc, r.exc, r.op);
                end
            end
        end
        if (end_req) begin
            checks++;
            if (rdy_q.size() != 0 || samp_q.size() != 0) begin
                errors++;
                $display("FAIL leftover rdy=%0d samp=%0d exp=0", rdy_q.size(), samp_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        int c0;
        logic ovf_exc;
`ifdef MULTDIV_MULT_OVF_EN
        mult_ovf = 1'b0;
        ovf_exc  = 1'b1;
`else
        ovf_exc  = 1'b0;
`endif
        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; divisor_zero = 1'b0;
        tick(3);
        push_s(cyc, vec(0,0,0,0,0,0,0,0,0,0), "reset_state");
        tick(1);
        reset = 1'b0;
        tick(2);

        // Reset mid-RUN at count 7
        c0 = cyc;
        ctrl_MULT = 1'b1; tick(1); ctrl_MULT = 1'b0;
        tick(8);
        push_s(c0 + 9, vec(1,1,0,0,1,1,0,0,0,7), "pre_reset_run7");
        @(negedge clock); #1;
        reset = 1'b1;
        tick(1);
        push_s(c0 + 10, vec(0,0,0,0,0,0,0,0,0,0), "after_reset");
        reset = 1'b0;
        tick(2);
        push_s(cyc, vec(0,0,0,0,0,0,0,0,0,0), "idle_after_reset");
        tick(1);

        // Multiply: 18-cycle latency
        c0 = cyc;
        push_s(c0, vec(0,0,0,0,0,1,0,0,0,0), "mult_start_stall");
        push_s(c0 + 1, vec(1,0,0,0,1,1,0,0,0,0), "mult_load");
        for (int k = 0; k < 16; k++)
            push_s(c0 + 2 + k, vec(1,1,0,0,1,1,0,0,0,k), "mult_run");
        push_s(c0 + 18, vec(0,0,0,0,0,0,0,1,0,15), "mult_done");
        push_s(c0 + 19, vec(0,0,0,0,0,0,0,0,0,15), "mult_idle");
        push_r(c0 + 18, 1'b0, 1'b0, "mult_rdy");
        ctrl_MULT = 1'b1; tick(1); ctrl_MULT = 1'b0;
        tick(20);

        // Divide: 34-cycle latency
        c0 = cyc;
        push_s(c0, vec(0,0,0,0,0,1,0,0,0,15), "div_start_stall");
        push_s(c0 + 1, vec(0,0,1,0,1,1,1,0,0,15), "div_load");
        for (int k = 0; k < 32; k++)
            push_s(c0 + 2 + k, vec(0,0,1,1,1,1,1,0,0,k), "div_run");
        push_s(c0 + 34, vec(0,0,0,0,0,0,1,1,0,31), "div_done");
        push_r(c0 + 34, 1'b0, 1'b1, "div_rdy");
        ctrl_DIV = 1'b1; tick(1); ctrl_DIV = 1'b0;
        tick(36);

        // Divide by zero: LOAD then DONE with exception
        c0 = cyc;
        divisor_zero = 1'b1;
        push_s(c0 + 1, vec(0,0,1,0,1,1,1,0,0,31), "dz_load");
        push_s(c0 + 2, vec(0,0,0,0,0,0,1,1,1,0), "dz_done");
        push_s(c0 + 3, vec(0,0,0,0,0,0,1,0,0,0), "dz_idle");
        push_r(c0 + 2, 1'b1, 1'b1, "dz_rdy");
        ctrl_DIV = 1'b1; tick(1); ctrl_DIV = 1'b0;
        tick(3);
        divisor_zero = 1'b0;
        tick(1);

        // Both starts: MULT wins; DIV at count 5 aborts and restarts
        c0 = cyc;
        push_s(c0 + 1, vec(1,0,0,0,1,1,0,0,0,0), "both_mult_load");
        push_s(c0 + 7, vec(1,1,0,0,1,1,0,0,0,5), "abort_run5");
        push_s(c0 + 8, vec(0,0,1,0,1,1,1,0,0,6), "abort_div_load");
        push_s(c0 + 41, vec(0,0,0,0,0,0,1,1,0,31), "abort_div_done");
        push_r(c0 + 41, 1'b0, 1'b1, "abort_div_rdy");
        ctrl_MULT = 1'b1; ctrl_DIV = 1'b1; tick(1);
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        tick(6);
        ctrl_DIV = 1'b1; tick(1); ctrl_DIV = 1'b0;
        tick(36);

        // Start during DONE: back-to-back issue (plus overflow when enabled)
        c0 = cyc;
        push_s(c0 + 1, vec(1,0,0,0,1,1,0,0,0,31), "b2b_mult_load");
        push_s(c0 + 17, vec(1,1,0,0,1,1,0,0,0,15), "b2b_mult_last");
        push_s(c0 + 18, vec(0,0,0,0,0,0,0,1,ovf_exc,15), "b2b_mult_done");
        push_s(c0 + 19, vec(0,0,1,0,1,1,1,0,0,15), "b2b_div_load");
        push_r(c0 + 18, ovf_exc, 1'b0, "b2b_mult_rdy");
        push_r(c0 + 52, 1'b0, 1'b1, "b2b_div_rdy");
        ctrl_MULT = 1'b1; tick(1); ctrl_MULT = 1'b0;
        tick(16);
`ifdef MULTDIV_MULT_OVF_EN
        mult_ovf = 1'b1;
`endif
        tick(1);
`ifdef MULTDIV_MULT_OVF_EN
        mult_ovf = 1'b0;
`endif
        ctrl_DIV = 1'b1; tick(1); ctrl_DIV = 1'b0;
        tick(37);

        end_req = 1'b1;
        tick(3);
        $display("FAIL monitor did not finish");
        $fatal(1);
    end

endmodule
